// File: rtl/ncl_pkg.sv
// Shared dual-rail encodings, handshake states and rail classification helpers
// for the NCL link blocks.
package ncl_pkg;

   localparam logic [1:0] DR_NULL = 2'b00;
   localparam logic [1:0] DR_0    = 2'b01;
   localparam logic [1:0] DR_1    = 2'b10;
   localparam logic [1:0] DR_ILL  = 2'b11;

   typedef enum logic {
      S_REQ_DATA,
      S_HOLD_DATA
   } state_t;

   function automatic logic dr_is_data(input logic [1:0] rails);
      return rails[1] ^ rails[0];
   endfunction

   function automatic logic dr_is_null(input logic [1:0] rails);
      return rails == DR_NULL;
   endfunction

   function automatic logic dr_is_ill(input logic [1:0] rails);
      return rails == DR_ILL;
   endfunction

endpackage

// File: rtl/ncl_dr_enc.sv
// Binary to dual-rail encoder: one rail pair per bit, bit i on dr[2i+1:2i].
// null_force drives every digit to NULL regardless of bin.
module ncl_dr_enc
   import ncl_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0]   bin,
   input  logic               null_force,
   output logic [2*WIDTH-1:0] dr
);

   always_comb begin
      // NOTE: default every combinational output first so no path can infer a latch.
      dr = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (null_force) dr[2*i +: 2] = DR_NULL;
         else            dr[2*i +: 2] = bin[i] ? DR_1 : DR_0;
      end
   end

endmodule

// File: rtl/ncl_sync_counter_link.sv
// Clocked modulo counter with NCL four-phase dual-rail carry-in, sum and carry-out links.
// Define NCL_CNT_INIT_DATA_EN to reset into a held DATA token (ring seeding).
module ncl_sync_counter_link
   import ncl_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH:0]   MODULUS  = {1'b1, {WIDTH{1'b0}}},
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic               clk,
   input  logic               init,
   input  logic [1:0]         carryin,
   output logic               carryinCOMP,
   output logic [2*WIDTH-1:0] sum,
   input  logic               sumCOMP,
   output logic [1:0]         carryout,
   input  logic               carryoutCOMP,
   output logic               err
);

   state_t             state;
   logic [WIDTH-1:0]   cnt;
   logic [WIDTH:0]     cnt_inc;
   logic               wrap;
   logic [WIDTH-1:0]   cnt_nxt;
   logic               null_out;
   logic               req_fire;
   logic               hold_fire;
   logic [2*WIDTH-1:0] sum_nxt;
   logic [1:0]         carryout_nxt;

   // One bit of headroom so a MODULUS of 2**WIDTH is detectable before truncation.
   assign cnt_inc = {1'b0, cnt} + {{WIDTH{1'b0}}, carryin[1]};
   assign wrap    = (cnt_inc == MODULUS);
   assign cnt_nxt = wrap ? '0 : cnt_inc[WIDTH-1:0];

   assign req_fire  = (state == S_REQ_DATA) && dr_is_data(carryin)
                      && !sumCOMP && !carryoutCOMP;
   assign hold_fire = (state == S_HOLD_DATA) && dr_is_null(carryin)
                      && sumCOMP && carryoutCOMP;

   // Leaving S_HOLD_DATA always emits NULL, so the same encoders serve both phases.
   assign null_out = (state == S_HOLD_DATA);

   ncl_dr_enc #(.WIDTH(WIDTH)) u_sum_enc (
      .bin        (cnt_nxt),
      .null_force (null_out),
      .dr         (sum_nxt)
   );

   ncl_dr_enc #(.WIDTH(1)) u_carryout_enc (
      .bin        (wrap),
      .null_force (null_out),
      .dr         (carryout_nxt)
   );

`ifdef NCL_CNT_INIT_DATA_EN
   logic [2*WIDTH-1:0] init_sum;

   ncl_dr_enc #(.WIDTH(WIDTH)) u_init_enc (
      .bin        (INIT_VAL),
      .null_force (1'b0),
      .dr         (init_sum)
   );
`endif

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register update order-independent.
      if (init) begin
         cnt <= INIT_VAL;
         err <= 1'b0;
`ifdef NCL_CNT_INIT_DATA_EN
         state       <= S_HOLD_DATA;
         sum         <= init_sum;
         carryout    <= DR_0;
         carryinCOMP <= 1'b1;
`else
         state       <= S_REQ_DATA;
         sum         <= '0;
         carryout    <= DR_NULL;
         carryinCOMP <= 1'b0;
`endif
      end else begin
         if (dr_is_ill(carryin)) err <= 1'b1;

         if (req_fire) begin
            cnt         <= cnt_nxt;
            sum         <= sum_nxt;
            carryout    <= carryout_nxt;
            carryinCOMP <= 1'b1;
            state       <= S_HOLD_DATA;
         end else if (hold_fire) begin
            sum         <= sum_nxt;
            carryout    <= carryout_nxt;
            carryinCOMP <= 1'b0;
            state       <= S_REQ_DATA;
         end
      end
   end

endmodule

// File: tb/tb_ncl_sync_counter_link.sv
// Bench for ncl_sync_counter_link: two WIDTH=4 instances (mod 16 from 0, mod 10 from 9)
// share one handshake, so their state sequence is identical while counts differ.
module tb_ncl_sync_counter_link;

   localparam int W = 4;

   typedef struct packed {
      logic [2*W-1:0] sa;
      logic [1:0]     ca;
      logic [2*W-1:0] sb;
      logic [1:0]     cb;
   } exp_t;

   typedef struct {
      logic [1:0] ci;
      exp_t       e;
   } vec_t;

   logic           clk = 1'b0;
   logic           init;
   logic [1:0]     carryin;
   logic           sumCOMP;
   logic           carryoutCOMP;

   logic           a_ci_comp, b_ci_comp;
   logic [2*W-1:0] a_sum, b_sum;
   logic [1:0]     a_co, b_co;
   logic           a_err, b_err;

   int   tests_run    = 0;
   int   tests_failed = 0;
   int   cnt_a, cnt_b;
   exp_t sb_q[$];
   vec_t vecs[18];

   always #5 clk = ~clk;

   ncl_sync_counter_link #(.WIDTH(W), .MODULUS(5'd16), .INIT_VAL(4'd0)) dut_a (
      .clk(clk), .init(init), .carryin(carryin), .carryinCOMP(a_ci_comp),
      .sum(a_sum), .sumCOMP(sumCOMP), .carryout(a_co),
      .carryoutCOMP(carryoutCOMP), .err(a_err)
   );

   ncl_sync_counter_link #(.WIDTH(W), .MODULUS(5'd10), .INIT_VAL(4'd9)) dut_b (
      .clk(clk), .init(init), .carryin(carryin), .carryinCOMP(b_ci_comp),
      .sum(b_sum), .sumCOMP(sumCOMP), .carryout(b_co),
      .carryoutCOMP(carryoutCOMP), .err(b_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] enc4(input logic [W-1:0] v);
      logic [2*W-1:0] r;
      for (int i = 0; i < W; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
      return r;
   endfunction

   task automatic model_step(input logic [1:0] ci, output exp_t e);
      int c;
      c = int'(ci[1]);
      cnt_a = cnt_a + c;
      if (cnt_a == 16) begin cnt_a = 0; e.ca = 2'b10; end
      else e.ca = 2'b01;
      cnt_b = cnt_b + c;
      if (cnt_b == 10) begin cnt_b = 0; e.cb = 2'b10; end
      else e.cb = 2'b01;
      e.sa = enc4(cnt_a[W-1:0]);
      e.sb = enc4(cnt_b[W-1:0]);
   endtask

   task automatic wait_comp(input logic lvl, output bit ok);
      int k = 0;
      while (a_ci_comp !== lvl && k < 20) begin
         @(negedge clk);
         k++;
      end
      ok = (a_ci_comp === lvl);
   endtask

   task automatic compare_pop();
      exp_t g;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 32'(sb_q.size()), 1);
         return;
      end
      g = sb_q.pop_front();
      check("sum_a",      a_sum,     g.sa);
      check("carryout_a", a_co,      g.ca);
      check("sum_b",      b_sum,     g.sb);
      check("carryout_b", b_co,      g.cb);
      check("ci_comp_b",  b_ci_comp, 1);
   endtask

   task automatic step_data(input logic [1:0] ci, input exp_t e);
      bit ok;
      @(negedge clk);
      carryin = ci;
      sb_q.push_back(e);
      wait_comp(1'b1, ok);
      if (!ok) begin
         check("data_timeout", a_ci_comp, 1);
         void'(sb_q.pop_front());
      end else begin
         compare_pop();
      end
   endtask

   task automatic null_phase();
      bit ok;
      @(negedge clk);
      carryin      = 2'b00;
      sumCOMP      = 1'b1;
      carryoutCOMP = 1'b1;
      wait_comp(1'b0, ok);
      check("null_ci_comp_a", a_ci_comp, 0);
      check("null_sum_a",     a_sum,     0);
      check("null_co_a",      a_co,      0);
      check("null_sum_b",     b_sum,     0);
      check("null_co_b",      b_co,      0);
      sumCOMP      = 1'b0;
      carryoutCOMP = 1'b0;
   endtask

   task automatic do_step(input logic [1:0] ci, input exp_t e);
      step_data(ci, e);
      null_phase();
   endtask

   task automatic do_reset();
      @(negedge clk);
      init         = 1'b1;
      carryin      = 2'b00;
      sumCOMP      = 1'b0;
      carryoutCOMP = 1'b0;
      @(negedge clk);
      cnt_a = 0;
      cnt_b = 9;
      sb_q.delete();
      check("rst_err_a", a_err, 0);
      check("rst_err_b", b_err, 0);
`ifdef NCL_CNT_INIT_DATA_EN
      check("rst_sum_a",     a_sum,     enc4(4'd0));
      check("rst_sum_b",     b_sum,     enc4(4'd9));
      check("rst_co_a",      a_co,      2'b01);
      check("rst_co_b",      b_co,      2'b01);
      check("rst_ci_comp_a", a_ci_comp, 1);
      init = 1'b0;
      null_phase();
`else
      check("rst_sum_a",     a_sum,     0);
      check("rst_sum_b",     b_sum,     0);
      check("rst_co_a",      a_co,      0);
      check("rst_co_b",      b_co,      0);
      check("rst_ci_comp_a", a_ci_comp, 0);
      init = 1'b0;
`endif
   endtask

   initial begin
      exp_t e;
      bit   ok;
      init         = 1'b1;
      carryin      = 2'b00;
      sumCOMP      = 1'b0;
      carryoutCOMP = 1'b0;
      cnt_a        = 0;
      cnt_b        = 9;
      repeat (2) @(negedge clk);

      do_reset();

      // 0..2 count up, 3 and 6 send value 0, the tail walks dut_a through 15 -> 0.
      for (int i = 0; i < 18; i++) begin
         vecs[i].ci = (i == 3 || i == 6) ? 2'b01 : 2'b10;
         model_step(vecs[i].ci, vecs[i].e);
      end
      for (int i = 0; i < 18; i++) do_step(vecs[i].ci, vecs[i].e);

      // Downstream not ready: DATA waits, and the value used is the one present when it fires.
      @(negedge clk);
      carryin = 2'b10;
      sumCOMP = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stall_ci_comp", a_ci_comp, 0);
      end
      model_step(2'b01, e);
      carryin = 2'b01;
      sumCOMP = 1'b0;
      sb_q.push_back(e);
      wait_comp(1'b1, ok);
      check("stall_fire", ok, 1);
      compare_pop();

      // sumCOMP lags for 7 cycles: DATA must stay held.
      carryin      = 2'b00;
      carryoutCOMP = 1'b1;
      repeat (7) begin
         @(negedge clk);
         check("lag_sum_held", a_sum,     e.sa);
         check("lag_ci_comp",  a_ci_comp, 1);
      end
      sumCOMP = 1'b1;
      @(negedge clk);
      check("lag_sum_null", a_sum,     0);
      check("lag_ci_null",  a_ci_comp, 0);
      sumCOMP      = 1'b0;
      carryoutCOMP = 1'b0;

      // Illegal carry-in: sticky err, no advance.
      @(negedge clk);
      carryin = 2'b11;
      @(negedge clk);
      check("ill_err_a",   a_err,     1);
      check("ill_err_b",   b_err,     1);
      check("ill_ci_comp", a_ci_comp, 0);
      check("ill_sum",     a_sum,     0);
      carryin = 2'b00;
      repeat (2) @(negedge clk);
      model_step(2'b10, e);
      do_step(2'b10, e);
      check("err_sticky", a_err, 1);

      // Reset in the middle of a handshake, then prove the count was reloaded.
      model_step(2'b10, e);
      step_data(2'b10, e);
      do_reset();
      model_step(2'b10, e);
      do_step(2'b10, e);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
